// File: rtl/hid_report_packer_pkg.sv
// Shared types and helpers for the HID boot-mouse report packer.
package hid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_BTN = 3'd1,
        ST_SEND_X   = 3'd2,
        ST_SEND_Y   = 3'd3,
        ST_SEND_W   = 3'd4
    } hid_state_t;

    localparam int HID_DELTA_MAX = 127;
    localparam int HID_DELTA_MIN = -127;
    localparam int BTN_PAD       = 5;

    // Clamp to the symmetric report range so -128 can never appear on the wire.
    function automatic logic signed [9:0] sat_add(input logic signed [9:0] acc,
                                                  input logic signed [7:0] delta);
        int sum;
        sum = int'(acc) + int'(delta);
        if (sum > HID_DELTA_MAX) begin
            sat_add = 10'(HID_DELTA_MAX);
        end else if (sum < HID_DELTA_MIN) begin
            sat_add = 10'(HID_DELTA_MIN);
        end else begin
            sat_add = 10'(sum);
        end
    endfunction

endpackage

// File: rtl/hid_report_packer_acc.sv
// Per-axis saturating movement accumulator with clear-on-take.
module delta_accumulator
    import hid_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              add,
    input  logic signed [7:0] delta,
    input  logic              take,
    output logic signed [9:0] take_value
);

    logic signed [9:0] acc;

    // Value handed to a snapshot includes any delta arriving in the same cycle.
    always_comb begin
        take_value = acc;
        if (add) begin
            take_value = sat_add(acc, delta);
        end else begin
            take_value = acc;
        end
    end

    // Accumulator register: a take consumes everything, including this cycle's delta.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 10'sd0;
        end else if (take) begin
            acc <= 10'sd0;
        end else if (add) begin
            acc <= sat_add(acc, delta);
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/hid_report_packer.sv
// Packs movement pulses into HID boot mouse reports streamed byte-wise over valid/ready.
module hid_report_packer
    import hid_pkg::*;
#(
    parameter int REPORT_BYTES  = 3,
    parameter bit SUPPRESS_IDLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_dx,
    input  logic [7:0]  in_dy,
    input  logic [2:0]  in_buttons,
    output logic [7:0]  ep_tdata,
    output logic        ep_tvalid,
    input  logic        ep_tready,
    output logic        ep_tlast,
    output logic        busy,
    output logic        coalesced,
    output logic [15:0] report_cnt
);

    if ((REPORT_BYTES != 3) && (REPORT_BYTES != 4)) begin : g_bad_report_bytes
        $error("hid_report_packer: REPORT_BYTES must be 3 or 4");
    end

    localparam hid_state_t LAST_STATE = (REPORT_BYTES == 4) ? ST_SEND_W : ST_SEND_Y;

    hid_state_t        state, state_nxt, base_nxt;
    logic              pending, accept, final_accept, want, load, suppress, merge;
    logic [2:0]        pend_buttons, last_buttons, load_btn, ref_btn;
    logic [2:0]        snap_btn, snap_btn_nxt;
    logic [7:0]        snap_x, snap_y, snap_x_nxt, snap_y_nxt, data_nxt;
    logic signed [9:0] take_x, take_y;

    delta_accumulator u_acc_x (
        .clk(clk), .rst(rst), .add(in_valid), .delta(in_dx),
        .take(load), .take_value(take_x)
    );

    delta_accumulator u_acc_y (
        .clk(clk), .rst(rst), .add(in_valid), .delta(in_dy),
        .take(load), .take_value(take_y)
    );

    // Snapshot decision: on the final beat the idle check compares against the buttons being sent now.
    always_comb begin
        accept       = ep_tvalid && ep_tready;
        final_accept = accept && (state == LAST_STATE);
        want         = in_valid || pending;
        load         = want && ((state == ST_IDLE) || final_accept);
        merge        = in_valid && (state != ST_IDLE) && !final_accept;
        load_btn     = in_valid ? in_buttons : pend_buttons;
        ref_btn      = final_accept ? snap_btn : last_buttons;
        suppress     = SUPPRESS_IDLE && (take_x == 10'sd0) && (take_y == 10'sd0)
                       && (load_btn == ref_btn);
    end

    // Next state, next frozen snapshot and the byte presented for that state.
    always_comb begin
        base_nxt = state;
        case (state)
            ST_IDLE:     base_nxt = ST_IDLE;
            ST_SEND_BTN: base_nxt = accept ? ST_SEND_X : ST_SEND_BTN;
            ST_SEND_X:   base_nxt = accept ? ST_SEND_Y : ST_SEND_X;
            ST_SEND_Y:   base_nxt = accept ? ((REPORT_BYTES == 4) ? ST_SEND_W : ST_IDLE) : ST_SEND_Y;
            ST_SEND_W:   base_nxt = accept ? ST_IDLE : ST_SEND_W;
            default:     base_nxt = ST_IDLE;
        endcase

        if (load && !suppress) begin
            state_nxt    = ST_SEND_BTN;
            snap_btn_nxt = load_btn;
            snap_x_nxt   = take_x[7:0];
            snap_y_nxt   = take_y[7:0];
        end else if (load) begin
            state_nxt    = ST_IDLE;
            snap_btn_nxt = snap_btn;
            snap_x_nxt   = snap_x;
            snap_y_nxt   = snap_y;
        end else begin
            state_nxt    = base_nxt;
            snap_btn_nxt = snap_btn;
            snap_x_nxt   = snap_x;
            snap_y_nxt   = snap_y;
        end

        case (state_nxt)
            ST_SEND_BTN: data_nxt = {{BTN_PAD{1'b0}}, snap_btn_nxt};
            ST_SEND_X:   data_nxt = snap_x_nxt;
            ST_SEND_Y:   data_nxt = snap_y_nxt;
            ST_SEND_W:   data_nxt = 8'h00;
            default:     data_nxt = 8'h00;
        endcase
    end

    // State, snapshot and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ep_tdata     <= 8'h00;
            ep_tvalid    <= 1'b0;
            ep_tlast     <= 1'b0;
            busy         <= 1'b0;
            coalesced    <= 1'b0;
            report_cnt   <= 16'd0;
            pending      <= 1'b0;
            pend_buttons <= 3'b000;
            last_buttons <= 3'b000;
            snap_btn     <= 3'b000;
            snap_x       <= 8'h00;
            snap_y       <= 8'h00;
        end else begin
            state        <= state_nxt;
            ep_tdata     <= data_nxt;
            ep_tvalid    <= (state_nxt != ST_IDLE);
            ep_tlast     <= (state_nxt == LAST_STATE);
            busy         <= (state_nxt != ST_IDLE);
            coalesced    <= merge;
            pending      <= load ? 1'b0 : (pending || merge);
            pend_buttons <= in_valid ? in_buttons : pend_buttons;
            snap_btn     <= snap_btn_nxt;
            snap_x       <= snap_x_nxt;
            snap_y       <= snap_y_nxt;
            if (final_accept) begin
                report_cnt   <= report_cnt + 16'd1;
                last_buttons <= snap_btn;
            end else begin
                report_cnt   <= report_cnt;
                last_buttons <= last_buttons;
            end
        end
    end

endmodule

// File: tb/tb_hid_report_packer.sv
// Directed bench for hid_report_packer (3-byte instance plus a 4-byte wheel variant).
module tb_hid_report_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_dx, in_dy;
    logic [2:0]  in_buttons;
    logic [7:0]  ep_tdata;
    logic        ep_tvalid, ep_tready, ep_tlast, busy, coalesced;
    logic [15:0] report_cnt;

    logic        in4_valid;
    logic [7:0]  in4_dx, in4_dy;
    logic [2:0]  in4_buttons;
    logic [7:0]  ep4_tdata;
    logic        ep4_tvalid, ep4_tready, ep4_tlast, busy4, coalesced4;
    logic [15:0] report4_cnt;

    int tests = 0;
    int fails = 0;
    int coal_seen;

    always #5 clk = ~clk;

    hid_report_packer #(.REPORT_BYTES(3), .SUPPRESS_IDLE(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dx(in_dx), .in_dy(in_dy),
        .in_buttons(in_buttons), .ep_tdata(ep_tdata), .ep_tvalid(ep_tvalid),
        .ep_tready(ep_tready), .ep_tlast(ep_tlast), .busy(busy),
        .coalesced(coalesced), .report_cnt(report_cnt)
    );

    hid_report_packer #(.REPORT_BYTES(4), .SUPPRESS_IDLE(1'b1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in4_valid), .in_dx(in4_dx), .in_dy(in4_dy),
        .in_buttons(in4_buttons), .ep_tdata(ep4_tdata), .ep_tvalid(ep4_tvalid),
        .ep_tready(ep4_tready), .ep_tlast(ep4_tlast), .busy(busy4),
        .coalesced(coalesced4), .report_cnt(report4_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] dx, input logic [7:0] dy,
                         input logic [2:0] btn);
        in_valid   = v;
        in_dx      = dx;
        in_dy      = dy;
        in_buttons = btn;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] data, input logic last);
        check({tag, "_data"}, 16'(ep_tdata), 16'(data));
        check({tag, "_valid"}, 16'(ep_tvalid), 16'd1);
        check({tag, "_last"}, 16'(ep_tlast), 16'(last));
    endtask

    initial begin
        rst = 1'b1;
        ep_tready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        in4_valid = 1'b0; in4_dx = 8'h00; in4_dy = 8'h00; in4_buttons = 3'b000;
        ep4_tready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 16'(ep_tvalid), 16'd0);
        check("rst_data", 16'(ep_tdata), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_cnt", report_cnt, 16'd0);

        // Basic send: 01, 05, FB with tlast on FB
        drive(1'b1, 8'd5, 8'hFB, 3'b001);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b001);
        expect_byte("basic_b0", 8'h01, 1'b0);
        check("basic_busy", 16'(busy), 16'd1);
        tick(); expect_byte("basic_b1", 8'h05, 1'b0);
        tick(); expect_byte("basic_b2", 8'hFB, 1'b1);
        tick();
        check("basic_idle", 16'(ep_tvalid), 16'd0);
        check("basic_cnt", report_cnt, 16'd1);

        // Back-pressure in SEND_X with three coalesced dx=100 pulses
        drive(1'b1, 8'd5, 8'hFB, 3'b001);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b001);
        expect_byte("bp_b0", 8'h01, 1'b0);
        tick(); expect_byte("bp_b1", 8'h05, 1'b0);
        ep_tready = 1'b0;
        coal_seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive((i == 1) || (i == 3) || (i == 5), 8'd100, 8'h00, 3'b001);
            tick();
            if (coalesced === 1'b1) coal_seen++;
            check("bp_hold_data", 16'(ep_tdata), 16'h05);
            check("bp_hold_valid", 16'(ep_tvalid), 16'd1);
        end
        drive(1'b0, 8'h00, 8'h00, 3'b001);
        check("bp_coal_count", 16'(coal_seen), 16'd3);
        ep_tready = 1'b1;
        tick(); expect_byte("bp_b2", 8'hFB, 1'b1);
        tick(); expect_byte("sat_b0", 8'h01, 1'b0);
        check("bp_cnt", report_cnt, 16'd2);
        tick(); expect_byte("sat_b1", 8'h7F, 1'b0);
        tick(); expect_byte("sat_b2", 8'h00, 1'b1);
        tick();
        check("sat_idle", 16'(ep_tvalid), 16'd0);
        check("sat_cnt", report_cnt, 16'd3);

        // -128 alone is clamped to -127
        drive(1'b1, 8'h80, 8'h00, 3'b001);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b001);
        expect_byte("neg_b0", 8'h01, 1'b0);
        tick(); expect_byte("neg_b1", 8'h81, 1'b0);
        tick(); expect_byte("neg_b2", 8'h00, 1'b1);
        tick();
        check("neg_cnt", report_cnt, 16'd4);

        // Idle suppression, then the same zero motion with a button change
        drive(1'b1, 8'h00, 8'h00, 3'b001);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b001);
        check("sup_valid", 16'(ep_tvalid), 16'd0);
        check("sup_busy", 16'(busy), 16'd0);
        tick();
        check("sup_valid2", 16'(ep_tvalid), 16'd0);
        check("sup_cnt", report_cnt, 16'd4);
        drive(1'b1, 8'h00, 8'h00, 3'b010);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b010);
        expect_byte("btn_b0", 8'h02, 1'b0);
        tick(); expect_byte("btn_b1", 8'h00, 1'b0);
        tick(); expect_byte("btn_b2", 8'h00, 1'b1);
        tick();
        check("btn_cnt", report_cnt, 16'd5);

        // Back-to-back: new sample in the cycle the final byte is accepted
        drive(1'b1, 8'd1, 8'd2, 3'b010);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b010);
        expect_byte("b2b_b0", 8'h02, 1'b0);
        tick(); expect_byte("b2b_b1", 8'h01, 1'b0);
        tick(); expect_byte("b2b_b2", 8'h02, 1'b1);
        drive(1'b1, 8'd3, 8'd4, 3'b100);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b100);
        expect_byte("b2b_n0", 8'h04, 1'b0);
        check("b2b_cnt", report_cnt, 16'd6);
        check("b2b_nocoal", 16'(coalesced), 16'd0);
        tick(); expect_byte("b2b_n1", 8'h03, 1'b0);
        tick(); expect_byte("b2b_n2", 8'h04, 1'b1);
        tick();
        check("b2b_idle", 16'(ep_tvalid), 16'd0);
        check("b2b_cnt2", report_cnt, 16'd7);

        // Reset mid-report with pending motion accumulated
        drive(1'b1, 8'd9, 8'd9, 3'b001);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b001);
        tick(); expect_byte("rm_b1", 8'h09, 1'b0);
        ep_tready = 1'b0;
        drive(1'b1, 8'd7, 8'h00, 3'b001);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ep_tready = 1'b1;
        check("rm_valid", 16'(ep_tvalid), 16'd0);
        check("rm_data", 16'(ep_tdata), 16'd0);
        check("rm_last", 16'(ep_tlast), 16'd0);
        check("rm_busy", 16'(busy), 16'd0);
        check("rm_coal", 16'(coalesced), 16'd0);
        check("rm_cnt", report_cnt, 16'd0);
        tick();
        check("rm_nopend", 16'(ep_tvalid), 16'd0);
        drive(1'b1, 8'd2, 8'd3, 3'b001);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b001);
        expect_byte("rm_n0", 8'h01, 1'b0);
        tick(); expect_byte("rm_n1", 8'h02, 1'b0);
        tick(); expect_byte("rm_n2", 8'h03, 1'b1);
        tick();
        check("rm_cnt2", report_cnt, 16'd1);

        // Four-byte variant appends a 0x00 wheel byte carrying tlast
        in4_valid = 1'b1; in4_dx = 8'd1; in4_dy = 8'hFF; in4_buttons = 3'b001;
        tick();
        in4_valid = 1'b0;
        check("w4_b0", 16'(ep4_tdata), 16'h01);
        check("w4_v0", 16'(ep4_tvalid), 16'd1);
        tick();
        check("w4_b1", 16'(ep4_tdata), 16'h01);
        tick();
        check("w4_b2", 16'(ep4_tdata), 16'hFF);
        check("w4_l2", 16'(ep4_tlast), 16'd0);
        tick();
        check("w4_b3", 16'(ep4_tdata), 16'h00);
        check("w4_l3", 16'(ep4_tlast), 16'd1);
        check("w4_v3", 16'(ep4_tvalid), 16'd1);
        tick();
        check("w4_idle", 16'(ep4_tvalid), 16'd0);
        check("w4_cnt", report4_cnt, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hid_report_packer.md
Name: hid_report_packer

Overview:
- Sits directly downstream of the mouse pattern generator and upstream of the USB interrupt-IN endpoint FIFO.
- Captures each per-report movement pulse (dx, dy, buttons) and packs it into a HID boot-protocol mouse report.
- Streams the report byte-by-byte over a valid/ready interface.
- While the endpoint is back-pressured, movement is coalesced into saturating accumulators so no motion is lost, only merged.

Parameters:
- REPORT_BYTES, 3: report length; 3 = {buttons, dx, dy}; 4 appends a wheel byte fixed at 8'h00. Other values are illegal (elaboration error).
- SUPPRESS_IDLE, 1: when 1, a report with dx = dy = 0 and buttons equal to the last sent buttons is discarded instead of sent.

Ports:
- clk  in  1  system clock (48 MHz)
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  one-cycle pulse: new movement sample present
- in_dx  in  8  signed two's-complement X delta
- in_dy  in  8  signed two's-complement Y delta
- in_buttons  in  3  {middle, right, left} button state
- ep_tdata  out  8  report byte
- ep_tvalid  out  1  ep_tdata valid
- ep_tready  in  1  endpoint accepts byte
- ep_tlast  out  1  marks final report byte
- busy  out  1  report in flight (state != IDLE)
- coalesced  out  1  one-cycle pulse when in_valid is merged into a pending accumulation
- report_cnt  out  16  reports fully sent; wraps at 65535 -> 0

Behaviour:
- Reset (rst = 1 at a clock edge): all of the following clear to 0 on that edge, regardless of state; any partially sent report is abandoned with no ep_tlast:
  - ep_tdata, ep_tvalid, ep_tlast, busy, coalesced, report_cnt
  - accumulators acc_x, acc_y
  - pending flag; last_buttons
  - state <= IDLE
- Accumulators: acc_x and acc_y are 10-bit signed.
  - Each in_valid adds the sign-extended delta.
  - The result is clamped to [-127, +127] every add, so an input of -128 becomes -127.
  - in_buttons overwrites pend_buttons (latest wins).
- FSM states: IDLE, SEND_BTN, SEND_X, SEND_Y, SEND_W.
- IDLE:
  - On in_valid, or pending = 1: form snapshot = clamp(acc + current input if in_valid), clear acc and pending, latch snapshot buttons.
  - If SUPPRESS_IDLE and the snapshot is idle (dx = dy = 0, buttons unchanged), stay in IDLE with no output.
  - Otherwise go to SEND_BTN.
- Latency: in_valid in IDLE at cycle N gives ep_tvalid = 1 with byte0 at cycle N+1.
- Byte order:
  - SEND_BTN: {5'b0, buttons}
  - SEND_X: dx
  - SEND_Y: dy
  - SEND_W: 8'h00, only when REPORT_BYTES = 4
- Advance to the next state only on ep_tvalid & ep_tready.
- ep_tdata and ep_tlast are held stable while ep_tvalid & !ep_tready.
- ep_tvalid stays high continuously from byte0 to the last byte; it never drops mid-report.
- ep_tlast = 1 only on the final byte.
- Final byte accepted:
  - report_cnt increments and last_buttons <= sent buttons.
  - If pending, or in_valid in the same cycle: load a new snapshot (same rule as IDLE) and go straight to SEND_BTN, with no idle bubble.
  - Otherwise go to IDLE; ep_tvalid = 0 next cycle.
- in_valid while state != IDLE: add to acc, set pending, pulse coalesced.
  - Exception: in_valid in the cycle the final byte is accepted is consumed by the new snapshot and does not pulse coalesced.
- The snapshot is frozen for the whole report; later inputs never alter bytes already in flight.

Decomposition:
- Package hid_pkg:
  - state enum hid_state_t
  - constants HID_DELTA_MAX = 127, HID_DELTA_MIN = -127
  - function sat_add(acc, delta) returning the clamped 10-bit value
  - BTN_PAD width constant
- Sub-module delta_accumulator, instantiated once per axis:
  - Performs saturating accumulate.
  - Has a clear-on-take port.
  - Provides a combinational take-value that includes a same-cycle input.

Test Plan:
- Basic send: ep_tready = 1, in_valid with dx = 5, dy = -5, btn = 3'b001 -> bytes 0x01, 0x05, 0xFB on consecutive cycles from N+1; ep_tlast on 0xFB; report_cnt = 1.
- Back-pressure: ep_tready = 0 for 10 cycles during SEND_X -> ep_tdata holds 0x05 and ep_tvalid stays 1; sequence resumes on ready.
- Coalescing and saturation:
  - While stalled, three pulses dx = 100 -> coalesced pulses 3 times.
  - The next report carries dx = 0x7F (127).
  - A dx = -128 input alone is sent as 0x81.
- Idle suppression: SUPPRESS_IDLE = 1, in_valid dx = 0, dy = 0, buttons unchanged -> ep_tvalid stays 0 and report_cnt unchanged; the same input with a buttons change is sent.
- Back-to-back: in_valid in the cycle the last byte is accepted -> next byte0 appears the following cycle with no gap; REPORT_BYTES = 4 variant emits a 0x00 fourth byte carrying ep_tlast.
- Reset mid-report: assert rst during SEND_X -> next cycle all outputs 0, state IDLE, accumulators cleared; a subsequent in_valid sends a fresh full report.
